pe_packet_engine: RTL
=====================

PE_PACKET_ENGINE -- requirements
Module: pe_packet_engine

Interface
REQ-001 Parameter: PACKET_WIDTH, 64, NIC data width; only 64 is supported.
REQ-002 Port: clk  input  1  rising-edge clock, the single clock of the block.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: start  input  1  one-cycle run request; ignored while busy=1.
REQ-005 Port: num_pkts  input  8  number of packets to transmit; sampled on accepted start.
REQ-006 Port: rx_expect  input  8  number of packets to receive; sampled on accepted start.
REQ-007 Port: hdr  input  32  packet upper word; sampled on accepted start.
REQ-008 Port: addr  output  2  NIC register select.
REQ-009 Port: d_in  output  64  write data to NIC.
REQ-010 Port: d_out  input  64  NIC read data; combinational, valid in the same cycle as the request.
REQ-011 Port: nicEn  output  1  NIC access enable.
REQ-012 Port: nicEnWR  output  1  NIC write enable; 1 = write, 0 = read.
REQ-013 Port: busy  output  1  high from an accepted start until done.
REQ-014 Port: done  output  1  one-cycle pulse at run completion.
REQ-015 Port: rx_count  output  8  packets read this run.
REQ-016 Port: rx_last  output  64  last packet read.
REQ-017 Port: err_count  output  8  sequence error count; saturates at 255.

Function
REQ-018 NIC map: addr 0 is the input buffer; addr 1 is input status (d_out[0]=1 means a packet is waiting); addr 2 is the output buffer; addr 3 is output status (d_out[0]=1 means full).
REQ-019 The state machine SHALL have the states IDLE, TX_POLL, TX_WR, RX_POLL, RX_RD and DONE.
REQ-020 addr, nicEn, nicEnWR and d_in SHALL be decoded from the state only (Moore outputs).
- In IDLE and DONE: nicEn=0, nicEnWR=0, addr=0.
REQ-021 IDLE + start: the block SHALL latch num_pkts, rx_expect and hdr, clear sent, rx_count and err_count, and go to TX_POLL.
- If num_pkts=0 and rx_expect=0, it SHALL go to DONE instead.
REQ-022 TX_POLL (addr=3, nicEn=1, read): next state SHALL be TX_WR if d_out[0]=0, otherwise RX_POLL.
REQ-023 TX_WR (addr=2, nicEn=1, nicEnWR=1, d_in={hdr_q, 24'b0, sent}): sent SHALL increment, then go to RX_POLL.
REQ-024 RX_POLL (addr=1, nicEn=1, read): next state SHALL be:
- RX_RD if d_out[0]=1 and rx_count<rx_expect;
- otherwise DONE if sent=num_pkts and rx_count=rx_expect;
- otherwise TX_POLL.
REQ-025 RX_RD (addr=0, nicEn=1, read): rx_last SHALL capture d_out, rx_count SHALL increment, then go to TX_POLL.
REQ-026 When sent=num_pkts, any transition to TX_POLL SHALL go to RX_POLL instead; no TX_WR occurs beyond num_pkts.
REQ-027 DONE SHALL assert done for exactly one cycle, then return to IDLE.
REQ-028 busy SHALL be 1 in every state except IDLE.
REQ-029 A NIC output-full status SHALL never cause data loss: a write occurs only after a poll returned d_out[0]=0 in the immediately preceding cycle.
REQ-030 A start received while busy=1 SHALL have no effect.

Reset
REQ-031 reset=1 at any clock edge, including mid-run, SHALL force the following and cancel any pending NIC access in that cycle:
- state IDLE, busy=0, done=0, nicEn=0, nicEnWR=0, addr=0, d_in=0;
- sent=0, rx_count=0, rx_last=0, err_count=0.
REQ-032 Latched hdr_q, num_pkts and rx_expect SHALL reset to 0.

Configuration
REQ-033 Macro PE_RX_CHECK_EN, when defined: in RX_RD, if d_out[31:0] differs from rx_count (pre-increment, zero-extended), err_count SHALL increment and saturate at 255.
REQ-034 Without PE_RX_CHECK_EN: err_count SHALL be constant 0 and no comparator logic is built.

Verification
REQ-035 Reset, then start with num_pkts=2, rx_expect=0, hdr=32'hA5A5_0001, NIC status always 0 -> writes 64'hA5A5_0001_0000_0000 and 64'hA5A5_0001_0000_0001 on addr 2, then a done pulse.
REQ-036 Output status held at 1 for 10 cycles -> no TX_WR while full; first write occurs in the cycle after the first poll reading 0.
REQ-037 rx_expect=3, input status 1 with d_out low words 0,1,2 -> rx_count=3, rx_last[31:0]=2, err_count=0, then done.
REQ-038 With PE_RX_CHECK_EN, received low words 0,5,2 -> err_count=1; without the macro -> err_count=0.
REQ-039 Reset asserted during TX_WR -> the next cycle shows nicEn=0, busy=0, sent=0; a new start runs a complete fresh transfer.
REQ-040 start with num_pkts=0 and rx_expect=0 -> done one cycle after start with no NIC access; a start pulsed while busy is ignored.

Source files
------------

// File: rtl/pe_packet_engine.sv
// Packet engine: interleaves polled transmits and receives against a 4-register NIC until the requested counts are done.
// Latency: one NIC register access per cycle; a run of N tx and M rx takes at least 2*N + 2*M + 2 cycles after start.
// Backpressure: writes stall while the NIC output status reads full; reads happen only while input status reports data.
//
// Ports:
//   clk, reset           single clock, synchronous active-high reset
//   start                run request, ignored while busy
//   num_pkts, rx_expect  packets to send / receive, latched on an accepted start
//   hdr                  upper 32 bits of every transmitted packet, latched on an accepted start
//   addr, nicEn, nicEnWR NIC register select, access enable, write enable (registered, state-decoded)
//   d_in                 NIC write data {hdr, 24'b0, sequence}
//   d_out                NIC read data, combinational for the current access
//   busy, done           run in progress / one-cycle completion pulse
//   rx_count, rx_last    packets read this run / last packet read
//   err_count            receive sequence errors, saturating
//
// Build option: define PE_RX_CHECK_EN to compare the low word of each received
// packet against its expected sequence number and count mismatches.
module pe_packet_engine #(
    parameter int PACKET_WIDTH = 64
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [7:0]              num_pkts,
    input  logic [7:0]              rx_expect,
    input  logic [31:0]             hdr,
    output logic [1:0]              addr,
    output logic [PACKET_WIDTH-1:0] d_in,
    input  logic [PACKET_WIDTH-1:0] d_out,
    output logic                    nicEn,
    output logic                    nicEnWR,
    output logic                    busy,
    output logic                    done,
    output logic [7:0]              rx_count,
    output logic [PACKET_WIDTH-1:0] rx_last,
    output logic [7:0]              err_count
);

    // NIC register map
    localparam logic [1:0] NIC_IN_BUF  = 2'd0;
    localparam logic [1:0] NIC_IN_STAT = 2'd1;
    localparam logic [1:0] NIC_OUT_BUF = 2'd2;
    localparam logic [1:0] NIC_OUT_STAT = 2'd3;

    typedef enum logic [2:0] {
        IDLE,
        TX_POLL,
        TX_WR,
        RX_POLL,
        RX_RD,
        DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [7:0]              sent_q;
    logic [7:0]              num_pkts_q;
    logic [7:0]              rx_expect_q;
    logic [7:0]              rx_count_q;
    logic [31:0]             hdr_q;
    logic [PACKET_WIDTH-1:0] rx_last_q;

    // Registered NIC-side outputs and their next values
    logic [1:0]              addr_q, addr_d;
    logic                    nic_en_q, nic_en_d;
    logic                    nic_wr_q, nic_wr_d;
    logic [PACKET_WIDTH-1:0] d_in_q, d_in_d;
    logic                    busy_q, done_q;

    logic tx_all_sent;
    logic rx_all_read;
    logic status_bit;
    // Once every packet is sent, a return to the tx side is redirected to rx polling
    state_t tx_or_rx;

    assign tx_all_sent = (sent_q == num_pkts_q);
    assign rx_all_read = (rx_count_q == rx_expect_q);
    assign status_bit  = d_out[0];
    assign tx_or_rx    = tx_all_sent ? RX_POLL : TX_POLL;

`ifdef PE_RX_CHECK_EN
    logic [7:0] err_count_q;
    logic       rx_seq_bad;

    // Sequence number carried in the low word is checked against the pre-increment count
    assign rx_seq_bad = (d_out[31:0] != {24'h0, rx_count_q});
    assign err_count  = err_count_q;
`else
    assign err_count  = 8'd0;
`endif

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (num_pkts == 8'd0 && rx_expect == 8'd0) begin
                        state_d = DONE;
                    end else if (num_pkts == 8'd0) begin
                        // sent is cleared on start, so nothing to send means go straight to rx
                        state_d = RX_POLL;
                    end else begin
                        state_d = TX_POLL;
                    end
                end
            end
            TX_POLL: state_d = status_bit ? RX_POLL : TX_WR;
            TX_WR:   state_d = RX_POLL;
            RX_POLL: begin
                if (status_bit && (rx_count_q < rx_expect_q)) begin
                    state_d = RX_RD;
                end else if (tx_all_sent && rx_all_read) begin
                    state_d = DONE;
                end else begin
                    state_d = tx_or_rx;
                end
            end
            RX_RD:   state_d = tx_or_rx;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NIC outputs decoded from the state being entered, so the registered
    // outputs always match the decode of the current state.
    always_comb begin
        addr_d   = NIC_IN_BUF;
        nic_en_d = 1'b0;
        nic_wr_d = 1'b0;
        d_in_d   = '0;
        case (state_d)
            TX_POLL: begin
                addr_d   = NIC_OUT_STAT;
                nic_en_d = 1'b1;
            end
            TX_WR: begin
                // TX_WR is only entered from TX_POLL, so hdr_q and sent_q are settled
                addr_d   = NIC_OUT_BUF;
                nic_en_d = 1'b1;
                nic_wr_d = 1'b1;
                d_in_d   = {hdr_q, 24'h0, sent_q};
            end
            RX_POLL: begin
                addr_d   = NIC_IN_STAT;
                nic_en_d = 1'b1;
            end
            RX_RD: begin
                addr_d   = NIC_IN_BUF;
                nic_en_d = 1'b1;
            end
            default: begin
                addr_d   = NIC_IN_BUF;
                nic_en_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            sent_q      <= 8'd0;
            num_pkts_q  <= 8'd0;
            rx_expect_q <= 8'd0;
            rx_count_q  <= 8'd0;
            hdr_q       <= 32'd0;
            rx_last_q   <= '0;
            addr_q      <= NIC_IN_BUF;
            nic_en_q    <= 1'b0;
            nic_wr_q    <= 1'b0;
            d_in_q      <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
`ifdef PE_RX_CHECK_EN
            err_count_q <= 8'd0;
`endif
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            nic_en_q <= nic_en_d;
            nic_wr_q <= nic_wr_d;
            d_in_q   <= d_in_d;
            busy_q   <= (state_d != IDLE);
            done_q   <= (state_d == DONE);

            case (state_q)
                IDLE: begin
                    if (start) begin
                        num_pkts_q  <= num_pkts;
                        rx_expect_q <= rx_expect;
                        hdr_q       <= hdr;
                        sent_q      <= 8'd0;
                        rx_count_q  <= 8'd0;
`ifdef PE_RX_CHECK_EN
                        err_count_q <= 8'd0;
`endif
                    end
                end
                TX_WR: begin
                    sent_q <= sent_q + 8'd1;
                end
                RX_RD: begin
                    rx_last_q  <= d_out;
                    rx_count_q <= rx_count_q + 8'd1;
`ifdef PE_RX_CHECK_EN
                    if (rx_seq_bad && (err_count_q != 8'hFF)) begin
                        err_count_q <= err_count_q + 8'd1;
                    end
`endif
                end
                default: begin
                end
            endcase
        end
    end

    assign addr     = addr_q;
    assign nicEn    = nic_en_q;
    assign nicEnWR  = nic_wr_q;
    assign d_in     = d_in_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign rx_count = rx_count_q;
    assign rx_last  = rx_last_q;

endmodule
